// File: rtl/vip_bayer_demosaic_5x5_8bit.sv
// 5x5 Malvar-style Bayer demosaic for 8-bit raw video: three pipeline stages
// (partial sums, weighted kernels, round/clamp/select) with syncs delayed to match.
module vip_bayer_demosaic_5x5_8bit #(
    parameter int BAYER_PATTERN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] matrix_p11, input logic [7:0] matrix_p12, input logic [7:0] matrix_p13,
    input  logic [7:0] matrix_p14, input logic [7:0] matrix_p15,
    input  logic [7:0] matrix_p21, input logic [7:0] matrix_p22, input logic [7:0] matrix_p23,
    input  logic [7:0] matrix_p24, input logic [7:0] matrix_p25,
    input  logic [7:0] matrix_p31, input logic [7:0] matrix_p32, input logic [7:0] matrix_p33,
    input  logic [7:0] matrix_p34, input logic [7:0] matrix_p35,
    input  logic [7:0] matrix_p41, input logic [7:0] matrix_p42, input logic [7:0] matrix_p43,
    input  logic [7:0] matrix_p44, input logic [7:0] matrix_p45,
    input  logic [7:0] matrix_p51, input logic [7:0] matrix_p52, input logic [7:0] matrix_p53,
    input  logic [7:0] matrix_p54, input logic [7:0] matrix_p55,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);

    typedef enum logic [1:0] {PH_R = 2'b00, PH_GR = 2'b01, PH_GB = 2'b10, PH_B = 2'b11} phase_e;

    // The pattern index doubles as the {row,col} phase of the top-left pixel.
    localparam logic [1:0] PAT_OFF = 2'(BAYER_PATTERN);

    // Window taps outside every kernel.
    logic unused_corner_taps;
    assign unused_corner_taps = ^{matrix_p11, matrix_p12, matrix_p14, matrix_p15, matrix_p21,
                                  matrix_p25, matrix_p41, matrix_p45, matrix_p51, matrix_p52,
                                  matrix_p54, matrix_p55};

    logic   vsync_q, href_q, row_par_q, row_par_d, col_par_q, col_par_d;
    logic   vsync_rise, href_rise, href_fall, col_eff;
    phase_e phase_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves one unassigned (no latch).
    always_comb begin
        vsync_rise = per_frame_vsync & ~vsync_q;
        href_rise  = per_frame_href & ~href_q;
        href_fall  = ~per_frame_href & href_q;
        // The first pixel of a line arrives in the href-rise cycle, so the clear must be seen at once.
        col_eff    = href_rise ? 1'b0 : col_par_q;
        row_par_d  = vsync_rise ? 1'b0 : (row_par_q ^ href_fall);
        col_par_d  = col_eff ^ (per_frame_clken & per_frame_href);
        phase_d    = phase_e'({(vsync_rise ? 1'b0 : row_par_q), col_eff} ^ PAT_OFF);
    end

    logic [7:0] c1_q;
    logic [8:0] ns1_q, we1_q, nnss1_q, wwee1_q;
    logic [9:0] d1_q;
    phase_e     ph1_q, ph2_q;
    logic [7:0] c2_q;
    logic signed [13:0] kg2_q, kh2_q, kv2_q, ko2_q;
    logic signed [13:0] c_s, ns_s, we_s, nnss_s, wwee_s, d_s;
    logic signed [13:0] kg_d, kh_d, kv_d, ko_d;
    logic [2:0] vs_sr_q, hr_sr_q, ce_sr_q;
    logic [7:0] red_q, green_q, blue_q, red_d, green_d, blue_d;

    always_comb begin
        c_s    = $signed(14'(c1_q));
        ns_s   = $signed(14'(ns1_q));
        we_s   = $signed(14'(we1_q));
        nnss_s = $signed(14'(nnss1_q));
        wwee_s = $signed(14'(wwee1_q));
        d_s    = $signed(14'(d1_q));
        kg_d = 14'sd8 * c_s + 14'sd4 * (ns_s + we_s) - 14'sd2 * (nnss_s + wwee_s);
        kh_d = 14'sd10 * c_s + 14'sd8 * we_s - 14'sd2 * wwee_s - 14'sd2 * d_s + nnss_s;
        kv_d = 14'sd10 * c_s + 14'sd8 * ns_s - 14'sd2 * nnss_s - 14'sd2 * d_s + wwee_s;
        ko_d = 14'sd12 * c_s + 14'sd4 * d_s - 14'sd3 * (nnss_s + wwee_s);
    end

    function automatic logic [7:0] round_clamp(input logic signed [13:0] k);
        logic signed [13:0] r;
        r = (k + 14'sd8) >>> 4;
        if (r < 14'sd0)        return 8'd0;
        else if (r > 14'sd255) return 8'd255;
        else                   return r[7:0];
    endfunction

    always_comb begin
        red_d   = c2_q;
        green_d = c2_q;
        blue_d  = c2_q;
        case (ph2_q)
            PH_R:  begin green_d = round_clamp(kg2_q); blue_d  = round_clamp(ko2_q); end
            PH_GR: begin red_d   = round_clamp(kh2_q); blue_d  = round_clamp(kv2_q); end
            PH_GB: begin red_d   = round_clamp(kv2_q); blue_d  = round_clamp(kh2_q); end
            PH_B:  begin red_d   = round_clamp(ko2_q); green_d = round_clamp(kg2_q); end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the previous stage's old value.
    // NOTE: the whole datapath is reset (not just control) because the outputs must read 0 during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0; href_q <= 1'b0; row_par_q <= 1'b0; col_par_q <= 1'b0;
            c1_q <= '0; ns1_q <= '0; we1_q <= '0; nnss1_q <= '0; wwee1_q <= '0; d1_q <= '0;
            ph1_q <= PH_R; ph2_q <= PH_R; c2_q <= '0;
            kg2_q <= '0; kh2_q <= '0; kv2_q <= '0; ko2_q <= '0;
            vs_sr_q <= '0; hr_sr_q <= '0; ce_sr_q <= '0;
            red_q <= '0; green_q <= '0; blue_q <= '0;
        end else begin
            vsync_q   <= per_frame_vsync;
            href_q    <= per_frame_href;
            row_par_q <= row_par_d;
            col_par_q <= col_par_d;
            c1_q    <= matrix_p33;
            ns1_q   <= 9'(matrix_p23) + 9'(matrix_p43);
            we1_q   <= 9'(matrix_p32) + 9'(matrix_p34);
            nnss1_q <= 9'(matrix_p13) + 9'(matrix_p53);
            wwee1_q <= 9'(matrix_p31) + 9'(matrix_p35);
            d1_q    <= 10'(matrix_p22) + 10'(matrix_p24) + 10'(matrix_p42) + 10'(matrix_p44);
            ph1_q   <= phase_d;
            ph2_q   <= ph1_q;
            c2_q    <= c1_q;
            kg2_q   <= kg_d; kh2_q <= kh_d; kv2_q <= kv_d; ko2_q <= ko_d;
            vs_sr_q <= {vs_sr_q[1:0], per_frame_vsync};
            hr_sr_q <= {hr_sr_q[1:0], per_frame_href};
            ce_sr_q <= {ce_sr_q[1:0], per_frame_clken};
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign post_frame_vsync = vs_sr_q[2];
    assign post_frame_href  = hr_sr_q[2];
    assign post_frame_clken = ce_sr_q[2];
    assign post_img_red     = red_q;
    assign post_img_green   = green_q;
    assign post_img_blue    = blue_q;

endmodule

// File: tb/tb_vip_bayer_demosaic_5x5_8bit.sv
// Directed bench for the Bayer demosaic: four instances (one per pattern) share the inputs.
module tb_vip_bayer_demosaic_5x5_8bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vs, hr, ce;
    logic [7:0] win [5][5];
    logic       pvs [4], phr [4], pce [4];
    logic [7:0] red [4], grn [4], blu [4];

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        vip_bayer_demosaic_5x5_8bit #(.BAYER_PATTERN(g)) u_dut (
            .clk(clk), .rst(rst),
            .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
            .matrix_p11(win[0][0]), .matrix_p12(win[0][1]), .matrix_p13(win[0][2]),
            .matrix_p14(win[0][3]), .matrix_p15(win[0][4]),
            .matrix_p21(win[1][0]), .matrix_p22(win[1][1]), .matrix_p23(win[1][2]),
            .matrix_p24(win[1][3]), .matrix_p25(win[1][4]),
            .matrix_p31(win[2][0]), .matrix_p32(win[2][1]), .matrix_p33(win[2][2]),
            .matrix_p34(win[2][3]), .matrix_p35(win[2][4]),
            .matrix_p41(win[3][0]), .matrix_p42(win[3][1]), .matrix_p43(win[3][2]),
            .matrix_p44(win[3][3]), .matrix_p45(win[3][4]),
            .matrix_p51(win[4][0]), .matrix_p52(win[4][1]), .matrix_p53(win[4][2]),
            .matrix_p54(win[4][3]), .matrix_p55(win[4][4]),
            .post_frame_vsync(pvs[g]), .post_frame_href(phr[g]), .post_frame_clken(pce[g]),
            .post_img_red(red[g]), .post_img_green(grn[g]), .post_img_blue(blu[g])
        );
    end

    task automatic cyc(input logic v, input logic h, input logic c);
        vs = v; hr = h; ce = c;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] val);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                win[r][c] = val;
    endtask

    // Bayer field (RGGB, R=200 G=100 B=50) whose centre sits on phase ph.
    task automatic fill_bayer(input logic [1:0] ph);
        logic [1:0] site;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                site = {ph[1] ^ r[0], ph[0] ^ c[0]};
                win[r][c] = (site == 2'b00) ? 8'd200 : (site == 2'b11) ? 8'd50 : 8'd100;
            end
    endtask

    // Starts a frame, steers the pattern-0 instance to centre phase ph, feeds one
    // window there, and returns at the cycle its result is on the outputs.
    task automatic run_phase(input logic [1:0] ph);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        if (ph[1]) begin
            cyc(0, 1, 0);
            cyc(0, 0, 0);
        end
        if (ph[0]) cyc(0, 1, 1);
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        fill(8'd100);
        cyc(1, 1, 1);
        cyc(1, 1, 1);
        cyc(1, 1, 1);
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if ({pvs[g], phr[g], pce[g], red[g], grn[g], blu[g]} !== 27'd0)
                $display("FAIL reset_state inst%0d got %h exp 0", g,
                         {pvs[g], phr[g], pce[g], red[g], grn[g], blu[g]});
            else n_pass++;
        end
        rst = 1'b0;
        fill(8'd0);
        cyc(0, 0, 0);
    endtask

    task automatic test_flat;
        fill(8'd100);
        for (int p = 0; p < 4; p++) begin
            run_phase(2'(p));
            n_checks++;
            if ({pce[0], red[0], grn[0], blu[0]} !== {1'b1, 8'd100, 8'd100, 8'd100})
                $display("FAIL flat_ph%0d got %h exp %h", p, {pce[0], red[0], grn[0], blu[0]},
                         {1'b1, 8'd100, 8'd100, 8'd100});
            else n_pass++;
        end
    endtask

    task automatic test_bayer;
        for (int p = 0; p < 4; p++) begin
            fill_bayer(2'(p));
            run_phase(2'(p));
            n_checks++;
            if ({pce[0], red[0], grn[0], blu[0]} !== {1'b1, 8'd200, 8'd100, 8'd50})
                $display("FAIL bayer_ph%0d got %h exp %h", p, {pce[0], red[0], grn[0], blu[0]},
                         {1'b1, 8'd200, 8'd100, 8'd50});
            else n_pass++;
        end
    endtask

    task automatic test_clamp;
        // Negative clamp: K_g=-2040 and K_o=-3060 both saturate to 0.
        fill(8'd0);
        win[0][2] = 8'd255; win[4][2] = 8'd255; win[2][0] = 8'd255; win[2][4] = 8'd255;
        run_phase(2'b00);
        n_checks++;
        if ({pce[0], red[0], grn[0], blu[0]} !== {1'b1, 8'd0, 8'd0, 8'd0})
            $display("FAIL clamp_low got %h exp %h", {pce[0], red[0], grn[0], blu[0]},
                     {1'b1, 8'd0, 8'd0, 8'd0});
        else n_pass++;
        // Positive clamp on a B site: R from K_o=7140 saturates, G=(2040+8)>>4=128.
        fill(8'd0);
        win[2][2] = 8'd255;
        win[1][1] = 8'd255; win[1][3] = 8'd255; win[3][1] = 8'd255; win[3][3] = 8'd255;
        run_phase(2'b11);
        n_checks++;
        if ({pce[0], red[0], grn[0], blu[0]} !== {1'b1, 8'd255, 8'd128, 8'd255})
            $display("FAIL clamp_high got %h exp %h", {pce[0], red[0], grn[0], blu[0]},
                     {1'b1, 8'd255, 8'd128, 8'd255});
        else n_pass++;
    endtask

    task automatic test_rounding;
        // R site, lone C=255: G=(2040+8)>>4=128, B=(3060+8)>>4=191.
        fill(8'd0);
        win[2][2] = 8'd255;
        run_phase(2'b00);
        n_checks++;
        if ({pce[0], red[0], grn[0], blu[0]} !== {1'b1, 8'd255, 8'd128, 8'd191})
            $display("FAIL rounding got %h exp %h", {pce[0], red[0], grn[0], blu[0]},
                     {1'b1, 8'd255, 8'd128, 8'd191});
        else n_pass++;
    endtask

    // Streams a 4x6 frame; checks syncs every cycle and the native channel of
    // every instance on every valid pixel, three clocks after it was presented.
    task automatic test_phase_sync;
        logic       s_vs [64], s_hr [64], s_ce [64];
        logic [7:0] s_c  [64];
        logic [1:0] s_rc [64];
        logic [1:0] p;
        logic [7:0] nat;
        int n, j, px, slots;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            s_vs[n] = (i == 2); s_hr[n] = 1'b0; s_ce[n] = 1'b0; s_c[n] = 8'd0; s_rc[n] = 2'b00; n++;
        end
        for (int l = 0; l < 4; l++) begin
            px = 0;
            slots = (l == 1) ? 7 : 6;
            for (int s = 0; s < slots; s++) begin
                s_vs[n] = 1'b0; s_hr[n] = 1'b1;
                if (l == 1 && s == 3) begin
                    s_ce[n] = 1'b0; s_c[n] = 8'd0; s_rc[n] = 2'b00;
                end else begin
                    s_ce[n] = 1'b1;
                    s_c[n]  = 8'(17 + 16 * l + 5 * px);
                    s_rc[n] = {l[0], px[0]};
                    px++;
                end
                n++;
            end
            for (int s = 0; s < 2; s++) begin
                s_vs[n] = 1'b0; s_hr[n] = 1'b0; s_ce[n] = 1'b1; s_c[n] = 8'd0; s_rc[n] = 2'b00; n++;
            end
        end
        for (int i = 0; i < n + 2; i++) begin
            fill(8'd0);
            if (i < n) begin
                win[2][2] = s_c[i];
                cyc(s_vs[i], s_hr[i], s_ce[i]);
            end else begin
                cyc(0, 0, 0);
            end
            j = i - 2;
            if (j >= 0) begin
                n_checks++;
                if ({pvs[0], phr[0], pce[0]} !== {s_vs[j], s_hr[j], s_ce[j]})
                    $display("FAIL sync_delay slot%0d got %b exp %b", j, {pvs[0], phr[0], pce[0]},
                             {s_vs[j], s_hr[j], s_ce[j]});
                else n_pass++;
                if (s_hr[j] && s_ce[j]) begin
                    for (int g = 0; g < 4; g++) begin
                        p = s_rc[j] ^ 2'(g);
                        nat = (p == 2'b00) ? red[g] : (p == 2'b11) ? blu[g] : grn[g];
                        n_checks++;
                        if (nat !== s_c[j])
                            $display("FAIL native_pat%0d slot%0d got %0d exp %0d", g, j, nat, s_c[j]);
                        else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midline;
        fill(8'd100);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        rst = 1'b1;
        cyc(0, 1, 1);
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if ({pvs[g], phr[g], pce[g], red[g], grn[g], blu[g]} !== 27'd0)
                $display("FAIL midline_reset inst%0d got %h exp 0", g,
                         {pvs[g], phr[g], pce[g], red[g], grn[g], blu[g]});
            else n_pass++;
        end
        rst = 1'b0;
        run_phase(2'b10);
        n_checks++;
        if ({pce[0], red[0], grn[0], blu[0]} !== {1'b1, 8'd100, 8'd100, 8'd100})
            $display("FAIL post_reset_flat got %h exp %h", {pce[0], red[0], grn[0], blu[0]},
                     {1'b1, 8'd100, 8'd100, 8'd100});
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; hr = 1'b0; ce = 1'b0;
        fill(8'd0);
        test_reset;
        test_flat;
        test_bayer;
        test_clamp;
        test_rounding;
        test_phase_sync;
        test_reset_midline;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
